ct_spsram_acc_ctrl: RTL

CT_SPSRAM_ACC_CTRL -- requirements
Module: ct_spsram_acc_ctrl

---
 rtl/ct_spsram_pkg.sv | 12 +
 rtl/ct_spsram_acc_ctrl_if.sv | 27 ++
 rtl/ct_spsram_rsp_fifo.sv | 42 ++++
 rtl/ct_spsram_acc_ctrl.sv | 121 ++++++++++++
 4 files changed

// File: rtl/ct_spsram_pkg.sv
// Shared sizing and FSM encoding for the single-port SRAM access controller.
package ct_spsram_pkg;
   localparam int ADDR_WIDTH = 11;
   localparam int DATA_WIDTH = 32;
   localparam int DEPTH      = 2048;
   localparam int RSP_DEPTH  = 2;

   typedef enum logic {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } state_t;
endpackage

// File: rtl/ct_spsram_acc_ctrl_if.sv
// Request/response bus of the SRAM access controller; valid/ready on both sides.
interface ct_spsram_acc_ctrl_if #(
   parameter int ADDR_WIDTH = ct_spsram_pkg::ADDR_WIDTH,
   parameter int DATA_WIDTH = ct_spsram_pkg::DATA_WIDTH
);
   import ct_spsram_pkg::*;

   logic                    req_vld;
   logic                    req_rdy;
   logic                    req_wr;
   logic [ADDR_WIDTH-1:0]   req_addr;
   logic [DATA_WIDTH-1:0]   req_wdata;
   logic [DATA_WIDTH/8-1:0] req_be;
   logic                    rsp_vld;
   logic                    rsp_rdy;
   logic [DATA_WIDTH-1:0]   rsp_rdata;

   modport master (
      output req_vld, req_wr, req_addr, req_wdata, req_be, rsp_rdy,
      input  req_rdy, rsp_vld, rsp_rdata
   );

   modport slave (
      input  req_vld, req_wr, req_addr, req_wdata, req_be, rsp_rdy,
      output req_rdy, rsp_vld, rsp_rdata
   );
endinterface

// File: rtl/ct_spsram_rsp_fifo.sv
// Two-entry read response FIFO; push lands the next cycle, head is combinational.
// Overflow is prevented upstream by the controller's ready term.
module ct_spsram_rsp_fifo #(
   parameter int DATA_WIDTH = ct_spsram_pkg::DATA_WIDTH
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  push,
   input  logic [DATA_WIDTH-1:0] push_dat,
   input  logic                  pop,
   output logic [DATA_WIDTH-1:0] pop_dat,
   output logic [1:0]            count
);
   import ct_spsram_pkg::*;

   logic [DATA_WIDTH-1:0] mem [RSP_DEPTH];
   logic                  wptr;
   logic                  rptr;

   always_ff @(posedge CLK) begin
      if (RST) begin
         wptr  <= 1'b0;
         rptr  <= 1'b0;
         count <= 2'd0;
      end else begin
         if (push) begin
            mem[wptr] <= push_dat;
            wptr      <= ~wptr;
         end
         if (pop) begin
            rptr <= ~rptr;
         end
         case ({push, pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end

   assign pop_dat = mem[rptr];
endmodule

// File: rtl/ct_spsram_acc_ctrl.sv
// Single-port SRAM controller: zero-fills the array after reset/clr_req, then serves
// byte-masked writes and 2-cycle reads; req_rdy drops once two reads are owed.
module ct_spsram_acc_ctrl #(
   parameter int ADDR_WIDTH = ct_spsram_pkg::ADDR_WIDTH,
   parameter int DATA_WIDTH = ct_spsram_pkg::DATA_WIDTH,
   parameter int DEPTH      = ct_spsram_pkg::DEPTH
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  clr_req,
   output logic                  init_done,
   ct_spsram_acc_ctrl_if.slave   bus,
   output logic [ADDR_WIDTH-1:0] A,
   output logic                  CEN,
   output logic                  GWEN,
   output logic [DATA_WIDTH-1:0] WEN,
   output logic [DATA_WIDTH-1:0] D,
   input  logic [DATA_WIDTH-1:0] Q
);
   import ct_spsram_pkg::*;

   localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(DEPTH - 1);

   state_t                state;
   logic [ADDR_WIDTH-1:0] cnt;
   logic [ADDR_WIDTH-1:0] a_q;
   logic [DATA_WIDTH-1:0] d_q;
   logic                  done_q;
   logic                  rd_inflight;
   logic [1:0]            fifo_count;
   logic                  acc;
   logic                  acc_rd;
   logic                  init_wr;
   logic                  pop;
   logic [DATA_WIDTH-1:0] be_wen;

   // Outputs are gated by RST because reset is only sampled at the clock edge.
   assign bus.req_rdy = !RST && (state == ST_RUN) &&
                        ((fifo_count + {1'b0, rd_inflight}) < 2'd2);
   assign acc         = bus.req_vld && bus.req_rdy;
   assign acc_rd      = acc && !bus.req_wr;
   assign init_wr     = !RST && (state == ST_INIT);
   assign init_done   = done_q && !RST;
   assign bus.rsp_vld = !RST && (fifo_count != 2'd0);
   assign pop         = bus.rsp_vld && bus.rsp_rdy;

   always_comb begin
      be_wen = '1;
      for (int k = 0; k < DATA_WIDTH/8; k++) begin
         if (bus.req_be[k]) be_wen[8*k +: 8] = 8'h00;
      end
      A    = a_q;
      D    = d_q;
      CEN  = 1'b1;
      GWEN = 1'b1;
      WEN  = '1;
      if (init_wr) begin
         A    = cnt;
         D    = '0;
         CEN  = 1'b0;
         GWEN = 1'b0;
         WEN  = '0;
      end else if (acc) begin
         A   = bus.req_addr;
         CEN = 1'b0;
         if (bus.req_wr) begin
            D    = bus.req_wdata;
            GWEN = ~|bus.req_be;
            WEN  = be_wen;
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state       <= ST_INIT;
         cnt         <= '0;
         done_q      <= 1'b0;
         rd_inflight <= 1'b0;
         a_q         <= '0;
         d_q         <= '0;
      end else begin
         rd_inflight <= acc_rd;
         if (!CEN) begin
            a_q <= A;
            d_q <= D;
         end
         case (state)
            ST_INIT: begin
               if (clr_req) begin
                  cnt <= '0;
               end else if (cnt == LAST) begin
                  state  <= ST_RUN;
                  done_q <= 1'b1;
                  cnt    <= '0;
               end else begin
                  cnt <= cnt + ADDR_WIDTH'(1);
               end
            end
            ST_RUN: begin
               if (clr_req) begin
                  state  <= ST_INIT;
                  cnt    <= '0;
                  done_q <= 1'b0;
               end
            end
            default: state <= ST_INIT;
         endcase
      end
   end

   ct_spsram_rsp_fifo #(.DATA_WIDTH(DATA_WIDTH)) u_rsp_fifo (
      .CLK      (CLK),
      .RST      (RST),
      .push     (rd_inflight),
      .push_dat (Q),
      .pop      (pop),
      .pop_dat  (bus.rsp_rdata),
      .count    (fifo_count)
   );
endmodule
